// File: rtl/m1_input_conditioner.sv
// Button front end for the M1 controller: per-channel 2-FF sync, debounce FSM and press-pulse logic.
// Optional macro M1_COND_REPEAT_EN adds auto-repeat of iM while the money button stays held.
module m1_input_conditioner #(
    parameter int DB_CYCLES     = 1_000_000,
    parameter int REPEAT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic R_n,
    input  logic btn_t,
    input  logic btn_m,
    input  logic btn_r,
    output logic iT,
    output logic iM,
    output logic R
);

    // state      | meaning
    // S_IDLE     | debounced low, input agrees
    // S_WAIT_HI  | input high, counting toward acceptance of a press
    // S_PRESSED  | debounced high, input agrees
    // S_WAIT_LO  | input low, counting toward acceptance of a release
    typedef enum logic [1:0] {S_IDLE, S_WAIT_HI, S_PRESSED, S_WAIT_LO} db_state_t;

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DB_CYCLES);
    localparam int CH_T = 0;
    localparam int CH_M = 1;
    localparam int CH_R = 2;

    if (DB_CYCLES < 2) begin : g_bad_db
        $error("m1_input_conditioner: DB_CYCLES must be at least 2");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_rpt
        $error("m1_input_conditioner: REPEAT_CYCLES must be at least 2");
    end

    logic [2:0]       sync1;
    logic [2:0]       sync2;
    db_state_t        state_q [3];
    db_state_t        state_d [3];
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [2:0]       deb;
    logic [2:0]       deb_d;
    logic [2:0]       rise;
    logic             rep_fire;

    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {btn_r, btn_m, btn_t};
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        deb = '0;
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            deb[i]     = (state_q[i] == S_PRESSED) || (state_q[i] == S_WAIT_LO);
            case (state_q[i])
                S_IDLE: begin
                    if (sync2[i]) begin
                        state_d[i] = S_WAIT_HI;
                        cnt_d[i]   = CNT_W'(1);
                    end
                end
                S_WAIT_HI: begin
                    if (!sync2[i]) begin
                        state_d[i] = S_IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] >= DB_MAX) begin
                        state_d[i] = S_PRESSED;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                S_PRESSED: begin
                    if (!sync2[i]) begin
                        state_d[i] = S_WAIT_LO;
                        cnt_d[i]   = CNT_W'(1);
                    end
                end
                S_WAIT_LO: begin
                    if (sync2[i]) begin
                        state_d[i] = S_PRESSED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] >= DB_MAX) begin
                        state_d[i] = S_IDLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = S_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    assign rise = deb & ~deb_d;

`ifdef M1_COND_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES);

    logic             pressed_m;
    logic [RPT_W-1:0] rpt_cnt;

    assign pressed_m = (state_q[CH_M] == S_PRESSED);
    assign rep_fire  = pressed_m && (rpt_cnt == RPT_MAX);

    // Counter restarts at 1 on every emitted iM so repeats are spaced from the last pulse.
    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            rpt_cnt <= '0;
        end else if (!pressed_m || deb[CH_R]) begin
            rpt_cnt <= '0;
        end else if (rise[CH_M] || rep_fire) begin
            rpt_cnt <= RPT_W'(1);
        end else begin
            rpt_cnt <= rpt_cnt + RPT_W'(1);
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // Gating with the pre-register R level keeps iT/iM low in every cycle where R is high.
    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            deb_d <= '0;
            iT    <= 1'b0;
            iM    <= 1'b0;
            R     <= 1'b0;
        end else begin
            deb_d <= deb;
            iT    <= rise[CH_T] & ~deb[CH_R];
            iM    <= (rise[CH_M] | rep_fire) & ~deb[CH_R];
            R     <= deb[CH_R];
        end
    end

endmodule

// File: tb/tb_m1_input_conditioner.sv
// Bench for m1_input_conditioner: directed scenarios plus random button activity,
// every cycle compared against a history-based reference model.
module tb_m1_input_conditioner;

    localparam int DB  = 4;
    localparam int RPT = 10;
    localparam int unsigned MASK = (1 << (DB + 1)) - 1;

    logic clk = 1'b0;
    logic R_n = 1'b1;
    logic btn_t = 1'b0;
    logic btn_m = 1'b0;
    logic btn_r = 1'b0;
    logic iT, iM, R;

    int tests = 0;
    int fails = 0;
    int cnt_t = 0;
    int cnt_m = 0;

    m1_input_conditioner #(.DB_CYCLES(DB), .REPEAT_CYCLES(RPT)) dut (
        .clk(clk), .R_n(R_n), .btn_t(btn_t), .btn_m(btn_m), .btn_r(btn_r),
        .iT(iT), .iM(iM), .R(R)
    );

    always #5 clk = ~clk;

    // Reference: a channel's level flips once its last DB+1 synchronized samples all disagree with it.
    bit [2:0]    pin_d1 = '0;
    bit [2:0]    pin_d2 = '0;
    bit [2:0]    m_deb = '0;
    bit [2:0]    m_deb_p = '0;
    bit [2:0]    m_s;
    bit [2:0]    m_rise;
    int unsigned sh [3] = '{0, 0, 0};
    int          cyc = 0;
    bit          e_iT = 1'b0;
    bit          e_iM = 1'b0;
    bit          e_R = 1'b0;
`ifdef M1_COND_REPEAT_EN
    int          anchor = 0;
    bit          m_clr;
    bit          m_fire;
`endif

    always @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            pin_d1 = '0; pin_d2 = '0; m_deb = '0; m_deb_p = '0;
            for (int c = 0; c < 3; c++) sh[c] = 0;
            e_iT = 1'b0; e_iM = 1'b0; e_R = 1'b0;
            cyc = 0;
`ifdef M1_COND_REPEAT_EN
            anchor = 0;
`endif
        end else begin
            cyc++;
            m_s    = pin_d2;
            pin_d2 = pin_d1;
            pin_d1 = {btn_r, btn_m, btn_t};
            m_rise = m_deb & ~m_deb_p;
            e_R    = m_deb[2];
            e_iT   = m_rise[0] & ~m_deb[2];
`ifdef M1_COND_REPEAT_EN
            // held means accepted high and the newest sample is still high
            m_clr  = !(m_deb[1] && ((sh[1] & 1) == 1)) || m_deb[2];
            m_fire = !m_clr && ((cyc - anchor) == RPT);
            e_iM   = (m_rise[1] | m_fire) & ~m_deb[2];
            if (m_clr) anchor = cyc + 1;
            else if (m_rise[1] || m_fire) anchor = cyc;
`else
            e_iM   = m_rise[1] & ~m_deb[2];
`endif
            m_deb_p = m_deb;
            for (int c = 0; c < 3; c++) begin
                sh[c] = ((sh[c] << 1) | int'(m_s[c])) & MASK;
                if (sh[c] == MASK) m_deb[c] = 1'b1;
                else if (sh[c] == 0) m_deb[c] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("model_iT", iT, e_iT);
            chk("model_iM", iM, e_iM);
            chk("model_R", R, e_R);
            if (iT === 1'b1) cnt_t++;
            if (iM === 1'b1) cnt_m++;
        end
    endtask

    initial begin
        int exp_rep;
`ifdef M1_COND_REPEAT_EN
        exp_rep = 4;
`else
        exp_rep = 1;
`endif
        // reset with all buttons held
        btn_t = 1'b1; btn_m = 1'b1; btn_r = 1'b1;
        #1 R_n = 1'b0;
        #1;
        chk("rst_iT", iT, 1'b0);
        chk("rst_iM", iM, 1'b0);
        chk("rst_R", R, 1'b0);
        tick(3);
        btn_r = 1'b0;
        R_n = 1'b1;
        tick(7);
        chk("rel_early_iT", iT, 1'b0);
        tick(1);
        chk("rel_lat_iT", iT, 1'b1);
        chk("simul_iM", iM, 1'b1);
        btn_t = 1'b0; btn_m = 1'b0;
        tick(15);

        // clean press
        cnt_t = 0;
        btn_t = 1'b1;
        tick(7);
        chk("clean_early", iT, 1'b0);
        tick(1);
        chk("clean_lat", iT, 1'b1);
        tick(12);
        btn_t = 1'b0;
        tick(15);
        chk_int("clean_count", cnt_t, 1);

        // bounce on btn_m
        cnt_m = 0;
        btn_m = 1'b1; tick(1);
        btn_m = 1'b0; tick(1);
        btn_m = 1'b1; tick(1);
        btn_m = 1'b0; tick(1);
        btn_m = 1'b1;
        tick(7);
        chk("bounce_early", iM, 1'b0);
        tick(1);
        chk("bounce_lat", iM, 1'b1);
        tick(2);
        btn_m = 1'b0;
        tick(15);
        chk_int("bounce_count", cnt_m, 1);

        // R priority over iT
        cnt_t = 0;
        btn_r = 1'b1;
        tick(10);
        btn_t = 1'b1;
        tick(12);
        chk("prio_R", R, 1'b1);
        btn_r = 1'b0; btn_t = 1'b0;
        tick(15);
        chk_int("prio_count", cnt_t, 0);

        // long hold on btn_m
        cnt_m = 0;
        btn_m = 1'b1;
        tick(40);
        btn_m = 1'b0;
        tick(15);
        chk_int("hold_count", cnt_m, exp_rep);

        // async reset while R is high, then re-debounce of a held button
        btn_r = 1'b1;
        tick(10);
        @(posedge clk);
        #2 R_n = 1'b0;
        #1;
        chk("async_R", R, 1'b0);
        chk("async_iT", iT, 1'b0);
        btn_r = 1'b0; btn_t = 1'b1;
        tick(2);
        R_n = 1'b1;
        tick(7);
        chk("redeb_early", iT, 1'b0);
        tick(1);
        chk("redeb_lat", iT, 1'b1);
        btn_t = 1'b0;
        tick(12);

        // random activity with hold lengths around the acceptance threshold
        for (int i = 0; i < 400; i++) begin
            btn_t = ($urandom_range(0, 1) == 1);
            btn_m = ($urandom_range(0, 1) == 1);
            btn_r = ($urandom_range(0, 5) == 0);
            tick(int'($urandom_range(1, 9)));
        end
        btn_t = 1'b0; btn_m = 1'b0; btn_r = 1'b0;
        tick(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
